// File: rtl/dem_pn_generator.sv
// Pseudorandom bit source for the DEM switching-block tree.
// One Fibonacci LFSR with strided taps drives one pn bit per block.
module dem_pn_generator #(
  parameter int unsigned LFSR_W = 15,
  parameter logic [LFSR_W-1:0] TAPS = 15'h6000,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 15'h0001,
  parameter int unsigned N_SB = 7,
  parameter int unsigned STRIDE = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [N_SB-1:0]   pn_seq_o,
  output logic              pn_valid_o,
  output logic              lockup_o,
  output logic              period_wrap_o
);

  // Last counter value before wrap: 2^LFSR_W - 2.
  localparam logic [LFSR_W-1:0] CNT_LAST = {{(LFSR_W-1){1'b1}}, 1'b0};

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] cnt_q;
  logic              valid_q;
  logic              lock_q;
  logic              wrap_q;
  logic              fb;

  assign fb = ^(state_q & TAPS);

  // The load point is tracked by the counter alone: a full maximal
  // period of advances after any load returns the state to it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SEED_DEFAULT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      lock_q <= 1'b0;
      wrap_q <= 1'b0;
      if (seed_load_i) begin
        cnt_q   <= '0;
        valid_q <= 1'b1;
        if (seed_i == '0) begin
          state_q <= SEED_DEFAULT;
          lock_q  <= 1'b1;
        end else begin
          state_q <= seed_i;
        end
      end else if (en_i) begin
        state_q <= {state_q[LFSR_W-2:0], fb};
        valid_q <= 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + LFSR_W'(1);
        end
      end
    end
  end

  // Spread output taps across the register to decorrelate adjacent blocks.
  for (genvar k = 0; k < N_SB; k++) begin : g_pn
    assign pn_seq_o[k] = state_q[(k*STRIDE) % LFSR_W];
  end

  assign pn_valid_o    = valid_q;
  assign lockup_o      = lock_q;
  assign period_wrap_o = wrap_q;

endmodule

// File: doc/dem_pn_generator.md
Name: dem_pn_generator

Overview:
- Pseudorandom bit source directly upstream of the switching-block tree in the DEM DAC.
- Produces one registered pn_seq bit per switching block from a single Fibonacci LFSR, with taps spread across the register to decorrelate adjacent blocks.
- Supports runtime seed load, zero-seed lock-up protection, advance enable (pn stalls when the modulator stalls), and a period-wrap marker for dither-period checks.

Parameters:
- LFSR_W, 15, LFSR register width in bits.
- TAPS, 15'h6000, feedback mask; bit i set means state[i] enters the XOR. Default is x^15+x^14+1, maximal length.
- SEED_DEFAULT, 15'h0001, state after reset and substitute for an all-zero seed. Must be nonzero.
- N_SB, 7, number of switching blocks fed (pn_seq_o width).
- STRIDE, 2, tap spacing between consecutive pn outputs.

Ports:
- clk_i  input  1  system clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- en_i  input  1  advance LFSR one step this cycle.
- seed_load_i  input  1  load seed_i this cycle; overrides en_i.
- seed_i  input  LFSR_W  seed value, sampled when seed_load_i=1.
- pn_seq_o  output  N_SB  pn bit per switching block; bit k feeds block k.
- pn_valid_o  output  1  pn_seq_o holds a sequence value.
- lockup_o  output  1  one-cycle pulse: all-zero seed rejected.
- period_wrap_o  output  1  one-cycle pulse: state has returned to the load-point state.

Behaviour:
- All state updates on the rising clk_i edge.
- reset_i=1 (sampled at the edge) sets:
  - state = SEED_DEFAULT, start = SEED_DEFAULT, advance counter = 0.
  - pn_valid_o=0, lockup_o=0, period_wrap_o=0.
  - reset_i overrides every other input, including mid-sequence.
- Priority per edge: reset_i > seed_load_i > en_i > hold.
- Seed load (seed_load_i=1):
  - seed_i != 0: state = seed_i, start = seed_i.
  - seed_i == 0: state = start = SEED_DEFAULT, and lockup_o=1 for the following cycle.
  - Counter is cleared; pn_valid_o=1 next cycle; period_wrap_o=0; en_i in the same cycle is ignored (no advance).
- Advance (en_i=1, no load):
  - fb = XOR over i of (state[i] & TAPS[i]).
  - state = {state[LFSR_W-2:0], fb}.
  - pn_valid_o=1 from the next cycle onward.
- Hold (en_i=0): state, counter and pn_seq_o are unchanged; pulse outputs return to 0.
- Output mapping: pn_seq_o[k] = state[(k*STRIDE) mod LFSR_W], taken combinationally from the state register. Output latency is 0 cycles after the state edge.
- Period counter:
  - Counter has LFSR_W bits and counts advances since the last load or reset.
  - On an advance with counter == 2^LFSR_W-2: counter goes to 0 and period_wrap_o=1 for one cycle, coinciding with state == start for a maximal polynomial.
  - Otherwise counter increments.
- Lock-up: an all-zero state is unreachable by construction (reset and load never produce it; maximal feedback never reaches it). No runtime correction beyond the load check is required.
- Pulse outputs are registered and high for exactly one cycle per event. Back-to-back zero-seed loads give consecutive lockup_o pulses.

Test Plan:
- Reset for 2 cycles, en_i=0 → state=0x0001, pn_seq_o=7'b0000001, pn_valid_o=0, lockup_o=0, period_wrap_o=0.
- From reset, en_i=1 for 2 cycles → state 0x0002 then 0x0004; pn_seq_o=7'b0000000 then 7'b0000010; pn_valid_o=1 after the first advance.
- From reset, 14 advances → state=0x4001; 15th advance → state=0x0003; pn_seq_o=7'b0000001.
- seed_load_i=1, seed_i=0x0000 → next cycle state=0x0001, lockup_o=1 for exactly one cycle. Then seed_i=0x1555 with en_i=1 in the same cycle → state=0x1555 (no advance), pn_seq_o=7'b1111111.
- From seed 0x0001, en_i=1 for 32767 cycles (with random en_i=0 gaps) → period_wrap_o pulses once exactly when state returns to 0x0001, never earlier; state never equals 0.
- Mid-sequence reset_i=1 while en_i=1 and seed_load_i=1 → next cycle state=0x0001, counter=0, pn_valid_o=0, no lockup_o or period_wrap_o pulse.
